// File: rtl/reg_write_arbiter.sv
// Four-requester write arbiter for a register bank: round-robin grant with a one-cycle turnaround.
// Define REGARB_FIXED_PRIO_EN to give requester 0 fixed priority, with round-robin among 1..3.
module reg_write_arbiter #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            req,
    input  logic [4*ADDR_W-1:0]   req_addr,
    input  logic [4*WIDTH-1:0]    req_data,
    output logic [3:0]            gnt,
    output logic [NUM_REGS-1:0]   load_n,
    output logic [WIDTH-1:0]      wr_data,
    output logic                  addr_err
);

    localparam logic [ADDR_W:0] NREGS_C = (ADDR_W+1)'(NUM_REGS);
`ifdef REGARB_FIXED_PRIO_EN
    localparam logic [1:0] RR_RST = 2'd1;
`else
    localparam logic [1:0] RR_RST = 2'd0;
`endif

    logic [3:0]          gnt_q, gnt_d;
    logic [NUM_REGS-1:0] load_n_q, load_n_d;
    logic [WIDTH-1:0]    wr_data_q, wr_data_d;
    logic                addr_err_q, addr_err_d;
    logic [1:0]          rr_ptr_q, rr_ptr_d;

    logic [ADDR_W-1:0]   addr_a [4];
    logic [WIDTH-1:0]    data_a [4];
    logic [3:0]          elig;
    logic                win_vld;
    logic [1:0]          win;
    logic [1:0]          k;
    logic [ADDR_W-1:0]   win_addr;
    logic                err;

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            addr_a[j] = req_addr[j*ADDR_W +: ADDR_W];
            data_a[j] = req_data[j*WIDTH +: WIDTH];
        end
    end

    // Last cycle's winner sits out one edge so it has time to drop req.
    always_comb begin
        elig    = req & ~gnt_q;
        win_vld = 1'b0;
        win     = 2'd0;
        k       = 2'd0;
`ifdef REGARB_FIXED_PRIO_EN
        if (elig[0]) begin
            win_vld = 1'b1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                k = 2'(((int'(rr_ptr_q) - 1 + i) % 3) + 1);
                if (!win_vld && elig[k]) begin
                    win_vld = 1'b1;
                    win     = k;
                end
            end
        end
`else
        for (int i = 0; i < 4; i++) begin
            k = rr_ptr_q + 2'(i);
            if (!win_vld && elig[k]) begin
                win_vld = 1'b1;
                win     = k;
            end
        end
`endif
    end

    always_comb begin
        win_addr   = addr_a[win];
        err        = ({1'b0, win_addr} >= NREGS_C);
        gnt_d      = win_vld ? (4'd1 << win) : 4'd0;
        addr_err_d = win_vld && err;
        wr_data_d  = win_vld ? data_a[win] : wr_data_q;
        load_n_d   = '1;
        for (int j = 0; j < NUM_REGS; j++) begin
            if (win_vld && !err && ({1'b0, win_addr} == (ADDR_W+1)'(j)))
                load_n_d[j] = 1'b0;
        end
        rr_ptr_d = rr_ptr_q;
`ifdef REGARB_FIXED_PRIO_EN
        if (win_vld && win != 2'd0)
            rr_ptr_d = (win == 2'd3) ? 2'd1 : win + 2'd1;
`else
        if (win_vld)
            rr_ptr_d = win + 2'd1;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_q      <= '0;
            load_n_q   <= '1;
            wr_data_q  <= '0;
            addr_err_q <= 1'b0;
            rr_ptr_q   <= RR_RST;
        end else begin
            gnt_q      <= gnt_d;
            load_n_q   <= load_n_d;
            wr_data_q  <= wr_data_d;
            addr_err_q <= addr_err_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign gnt      = gnt_q;
    assign load_n   = load_n_q;
    assign wr_data  = wr_data_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: vector table, corner sequences and random traffic vs a reference model.
module tb_reg_write_arbiter;
    localparam int WIDTH    = 32;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 4;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [3:0]            req = '0;
    logic [4*ADDR_W-1:0]   req_addr = '0;
    logic [4*WIDTH-1:0]    req_data = '0;
    logic [3:0]            gnt;
    logic [NUM_REGS-1:0]   load_n;
    logic [WIDTH-1:0]      wr_data;
    logic                  addr_err;

    reg_write_arbiter #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt), .load_n(load_n), .wr_data(wr_data), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    // Downstream register bank, captures on the edge after a load strobe.
    logic [WIDTH-1:0] bank [NUM_REGS];
    initial for (int i = 0; i < NUM_REGS; i++) bank[i] = '0;
    always @(posedge clk)
        for (int i = 0; i < NUM_REGS; i++)
            if (!load_n[i]) bank[i] <= wr_data;

    int tests = 0;
    int fails = 0;

    // Reference model: last winner (-1 none), search start, last written data.
    int              m_prev;
    int              m_rr;
    logic [WIDTH-1:0] m_wd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = -1;
`ifdef REGARB_FIXED_PRIO_EN
        m_rr = 1;
`else
        m_rr = 0;
`endif
        m_wd = '0;
    endtask

    task automatic set_req(input int r, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        req[r] = 1'b1;
        req_addr[r*ADDR_W +: ADDR_W] = a;
        req_data[r*WIDTH +: WIDTH] = d;
    endtask

    // One clock: predict from the current requests, clock, compare all outputs.
    task automatic step();
        int w;
        logic [3:0] eg;
        logic [NUM_REGS-1:0] el;
        logic ee;
        logic [WIDTH-1:0] ed;
        logic [ADDR_W-1:0] a;
        w = -1;
`ifdef REGARB_FIXED_PRIO_EN
        if (req[0] && m_prev != 0) w = 0;
        else
            for (int i = 0; i < 3; i++) begin
                int c;
                c = 1 + ((m_rr - 1 + i) % 3);
                if (w < 0 && req[c] && m_prev != c) w = c;
            end
`else
        for (int i = 0; i < 4; i++) begin
            int c;
            c = (m_rr + i) % 4;
            if (w < 0 && req[c] && m_prev != c) w = c;
        end
`endif
        eg = '0; el = '1; ee = 1'b0; ed = m_wd; a = '0;
        if (w >= 0) begin
            eg[w] = 1'b1;
            a  = req_addr[w*ADDR_W +: ADDR_W];
            ed = req_data[w*WIDTH +: WIDTH];
            if (int'(a) >= NUM_REGS) ee = 1'b1;
            else el[int'(a)] = 1'b0;
`ifdef REGARB_FIXED_PRIO_EN
            if (w != 0) m_rr = (w == 3) ? 1 : w + 1;
`else
            m_rr = (w + 1) % 4;
`endif
        end
        @(posedge clk); #1;
        chk("model_gnt", 64'(gnt), 64'(eg));
        chk("model_load_n", 64'(load_n), 64'(el));
        chk("model_wr_data", 64'(wr_data), 64'(ed));
        chk("model_addr_err", 64'(addr_err), 64'(ee));
        m_prev = w;
        m_wd = ed;
    endtask

    typedef struct {
        int                  r;
        logic [ADDR_W-1:0]   a;
        logic [WIDTH-1:0]    d;
        logic [3:0]          e_gnt;
        logic [NUM_REGS-1:0] e_load_n;
        logic                e_err;
    } vec_t;
    vec_t vec [7];

    initial begin
        vec[0] = '{2, 4'd5,  32'hDEADBEEF, 4'b0100, 8'b1101_1111, 1'b0};
        vec[1] = '{1, 4'd9,  32'h1234_5678, 4'b0010, 8'hFF,       1'b1};
        vec[2] = '{0, 4'd0,  32'hA5A5_0000, 4'b0001, 8'hFE,       1'b0};
        vec[3] = '{3, 4'd7,  32'h0000_0777, 4'b1000, 8'h7F,       1'b0};
        vec[4] = '{2, 4'd15, 32'hFFFF_FFFF, 4'b0100, 8'hFF,       1'b1};
        vec[5] = '{1, 4'd8,  32'h8888_8888, 4'b0010, 8'hFF,       1'b1};
        vec[6] = '{0, 4'd3,  32'h0303_0303, 4'b0001, 8'hF7,       1'b0};

        model_reset();
        #12;
        chk("rst_gnt", 64'(gnt), 64'(4'b0));
        chk("rst_load_n", 64'(load_n), 64'({NUM_REGS{1'b1}}));
        chk("rst_wr_data", 64'(wr_data), 64'(0));
        chk("rst_addr_err", 64'(addr_err), 64'(0));
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // All four request together and each drops on its grant.
        for (int r = 0; r < 4; r++) set_req(r, ADDR_W'(r), WIDTH'(32'h100 + r));
        for (int c = 0; c < 4; c++) begin
            logic [3:0] one;
            logic [NUM_REGS-1:0] ln;
            step();
            one = 4'd1 << c;
            ln = '1; ln[c] = 1'b0;
            chk("rr_seq_gnt", 64'(gnt), 64'(one));
            chk("rr_seq_load_n", 64'(load_n), 64'(ln));
            req = req & ~gnt;
        end
        step();

        foreach (vec[i]) begin
            set_req(vec[i].r, vec[i].a, vec[i].d);
            step();
            chk("vec_gnt", 64'(gnt), 64'(vec[i].e_gnt));
            chk("vec_load_n", 64'(load_n), 64'(vec[i].e_load_n));
            chk("vec_wr_data", 64'(wr_data), 64'(vec[i].d));
            chk("vec_addr_err", 64'(addr_err), 64'(vec[i].e_err));
            req = '0;
            step();
            chk("vec_idle_gnt", 64'(gnt), 64'(4'b0));
            chk("vec_idle_load_n", 64'(load_n), 64'({NUM_REGS{1'b1}}));
            chk("vec_idle_hold", 64'(wr_data), 64'(vec[i].d));
            chk("vec_idle_err", 64'(addr_err), 64'(0));
        end

        // Same address from 0 and 3 with the pointer parked at 3.
        set_req(2, 4'd1, 32'h2222);
        step();
        req = '0;
        step();
        set_req(0, 4'd2, 32'd1);
        set_req(3, 4'd2, 32'd3);
        step();
`ifdef REGARB_FIXED_PRIO_EN
        chk("same_addr_first", 64'(gnt), 64'(4'b0001));
`else
        chk("same_addr_first", 64'(gnt), 64'(4'b1000));
`endif
        req = req & ~gnt;
        step();
`ifdef REGARB_FIXED_PRIO_EN
        chk("same_addr_second", 64'(gnt), 64'(4'b1000));
`else
        chk("same_addr_second", 64'(gnt), 64'(4'b0001));
`endif
        req = req & ~gnt;
        step();
`ifdef REGARB_FIXED_PRIO_EN
        chk("same_addr_final", 64'(bank[2]), 64'(32'd3));
`else
        chk("same_addr_final", 64'(bank[2]), 64'(32'd1));
`endif

        // Asynchronous reset in the middle of a grant cycle; held request is re-granted.
        set_req(0, 4'd1, 32'h55);
        step();
        chk("pre_rst_gnt", 64'(gnt), 64'(4'b0001));
        #3 reset = 1'b0;
        #1;
        chk("async_rst_gnt", 64'(gnt), 64'(4'b0));
        chk("async_rst_load_n", 64'(load_n), 64'({NUM_REGS{1'b1}}));
        chk("async_rst_wr_data", 64'(wr_data), 64'(0));
        model_reset();
        #2 reset = 1'b1;
        step();
        chk("post_rst_gnt", 64'(gnt), 64'(4'b0001));
        chk("post_rst_load_n", 64'(load_n), 64'(8'hFD));
        req = '0;
        step();

        // Two requesters holding req continuously.
`ifdef REGARB_FIXED_PRIO_EN
        set_req(0, 4'd4, 32'h40);
        set_req(2, 4'd6, 32'h60);
        for (int c = 0; c < 6; c++) begin
            step();
            chk("fixed_alt_gnt", 64'(gnt), 64'((c % 2 == 0) ? 4'b0001 : 4'b0100));
        end
`else
        set_req(1, 4'd4, 32'h40);
        set_req(3, 4'd6, 32'h60);
        for (int c = 0; c < 6; c++) begin
            step();
            chk("throughput_gnt", 64'(gnt != 4'b0), 64'(1));
        end
`endif
        req = '0;
        step();

        // Random traffic: requesters raise at random, drop on seeing their grant.
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (gnt[r]) req[r] = 1'b0;
                else if (!req[r] && ($urandom % 3 == 0))
                    set_req(r, ADDR_W'($urandom_range(0, 15)), $urandom);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
